// File: rtl/lpif_arb_pkg.sv
// Shared types for the LPIF downstream protid arbiter: FSM encoding and debug-status layout.
// Pure declarations, no timing and no flow control of its own.
package lpif_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    localparam int ARB_DBG_STATE_LSB = 0;
    localparam int ARB_DBG_OWNER_LSB = 2;
    localparam int ARB_DBG_OWNER_W   = 3;
    localparam int ARB_DBG_ABORT     = 5;
    localparam int ARB_DBG_CNT_LSB   = 16;
    localparam int ARB_DBG_CNT_W     = 16;

    // Message counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lpif_dstrm_protid_arbiter_if.sv
// Requester-side and downstream-side flit handshake of the protid arbiter.
// Valid/ready on both sides; slave = arbiter view, master = environment view.
interface lpif_dstrm_protid_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int DVALID_WIDTH = 2,
    parameter int PROTID_WIDTH = 4
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
    logic [NUM_REQ*DVALID_WIDTH-1:0] req_dvalid;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            dstrm_ready;
    logic                            dstrm_valid;
    logic [PROTID_WIDTH-1:0]         dstrm_protid;
    logic [DATA_WIDTH-1:0]           dstrm_data;
    logic [DVALID_WIDTH-1:0]         dstrm_dvalid;

    modport slave (
        input  req_valid, req_last, req_data, req_dvalid, dstrm_ready,
        output req_ready, dstrm_valid, dstrm_protid, dstrm_data, dstrm_dvalid
    );

    modport master (
        output req_valid, req_last, req_data, req_dvalid, dstrm_ready,
        input  req_ready, dstrm_valid, dstrm_protid, dstrm_data, dstrm_dvalid
    );
endinterface

// File: rtl/lpif_rr_pick.sv
// Round-robin pick: first set req_valid bit at or after rr_ptr, wrapping modulo NUM_REQ.
// Purely combinational, no backpressure.
module lpif_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    assign any = |req_valid;

    // Walk from farthest to nearest so the slot closest to rr_ptr overwrites last.
    always_comb begin
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (req_valid[idx]) begin
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/lpif_dstrm_protid_arbiter.sv
// Shares one LPIF downstream flit channel among NUM_REQ requesters, locked per message, round-robin.
// Latency 1 cycle accept-to-output; holds the output flit while dstrm_ready is low, gated by tx_online.
module lpif_dstrm_protid_arbiter
    import lpif_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int DVALID_WIDTH = 2,
    parameter int PROTID_WIDTH = 4
) (
    input  logic                            clk_wr,
    input  logic                            rst_wr_n,
    input  logic                            tx_online,
    input  logic [NUM_REQ*PROTID_WIDTH-1:0] cfg_protid,
    lpif_dstrm_protid_arbiter_if.slave      bus,
    output logic [31:0]                     arb_debug_status
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [PROTID_WIDTH-1:0] protid;
        logic [DVALID_WIDTH-1:0] dvalid;
        logic [DATA_WIDTH-1:0]   data;
    } flit_t;

    arb_state_e   state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [OW-1:0] owner_nxt;
    logic [OW-1:0] winner;
    logic          any;
    logic          abort_q, abort_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          ovld_q, ovld_d;
    flit_t         obuf_q, obuf_d, flit_mux;
    logic          obuf_free;
    logic [NUM_REQ-1:0] rdy;
    logic          accept;
    logic          own_last;

    lpif_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(OW)) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_q),
        .winner    (winner),
        .any       (any)
    );

    assign obuf_free = !ovld_q | bus.dstrm_ready;
    assign owner_nxt = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign own_last  = bus.req_last[owner_q];
    assign accept    = |(bus.req_valid & rdy);

    always_comb begin
        rdy = '0;
        if (state_q == ARB_LOCK && tx_online && obuf_free) begin
            rdy[owner_q] = 1'b1;
        end
    end

    always_comb begin
        flit_mux.protid = cfg_protid[owner_q*PROTID_WIDTH +: PROTID_WIDTH];
        flit_mux.dvalid = bus.req_dvalid[owner_q*DVALID_WIDTH +: DVALID_WIDTH];
        flit_mux.data   = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        abort_d = abort_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (tx_online && any) begin
                    state_d = ARB_LOCK;
                    owner_d = winner;
                end
            end
            ARB_LOCK: begin
                if (accept && own_last) begin
                    state_d = ARB_IDLE;
                    rr_d    = owner_nxt;
                    cnt_d   = sat_inc16(cnt_q);
                end else if (!tx_online) begin
                    // Link lost mid-message: the partial message is abandoned.
                    state_d = ARB_DRAIN;
                    abort_d = 1'b1;
                    rr_d    = owner_nxt;
                end
            end
            ARB_DRAIN: begin
                if (!ovld_q) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ovld_d = ovld_q;
        obuf_d = obuf_q;
        if (accept) begin
            ovld_d = 1'b1;
            obuf_d = flit_mux;
        end else if (obuf_free) begin
            ovld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
            ovld_q  <= 1'b0;
            obuf_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
            ovld_q  <= ovld_d;
            obuf_q  <= obuf_d;
        end
    end

    always_comb begin
        arb_debug_status = '0;
        arb_debug_status[ARB_DBG_STATE_LSB +: 2]             = state_q;
        arb_debug_status[ARB_DBG_OWNER_LSB +: OW]            = owner_q;
        arb_debug_status[ARB_DBG_ABORT]                      = abort_q;
        arb_debug_status[ARB_DBG_CNT_LSB +: ARB_DBG_CNT_W]   = cnt_q;
    end

    assign bus.req_ready    = rdy;
    assign bus.dstrm_valid  = ovld_q;
    assign bus.dstrm_protid = obuf_q.protid;
    assign bus.dstrm_dvalid = obuf_q.dvalid;
    assign bus.dstrm_data   = obuf_q.data;
endmodule

// File: tb/tb_lpif_dstrm_protid_arbiter.sv
// Directed bench for the protid arbiter: vector table for single-owner and round-robin traffic,
// then hand sequences for lock hold, backpressure, link drop and mid-message reset.
module tb_lpif_dstrm_protid_arbiter;
    import lpif_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int VW = 2;
    localparam int PW = 4;

    logic          clk_wr = 1'b0;
    logic          rst_wr_n;
    logic          tx_online;
    logic [N*PW-1:0] cfg_protid;
    logic [31:0]   arb_debug_status;

    always #5 clk_wr = ~clk_wr;

    lpif_dstrm_protid_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .DVALID_WIDTH(VW), .PROTID_WIDTH(PW)) bus ();

    lpif_dstrm_protid_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DVALID_WIDTH(VW), .PROTID_WIDTH(PW)) dut (
        .clk_wr           (clk_wr),
        .rst_wr_n         (rst_wr_n),
        .tx_online        (tx_online),
        .cfg_protid       (cfg_protid),
        .bus              (bus.slave),
        .arb_debug_status (arb_debug_status)
    );

    typedef struct {
        logic        rst;
        logic        tx;
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic [7:0]  dat;
        logic        e_v;
        logic [3:0]  e_rdy;
        logic [3:0]  e_pid;
        logic [15:0] e_dat;
        logic [1:0]  e_dv;
        logic [1:0]  e_st;
        logic [2:0]  e_own;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    // Every slice carries the same message byte, tagged with its requester index.
    task automatic drive(input logic [3:0] rv, input logic [3:0] rl, input logic [7:0] dat);
        bus.req_valid = rv;
        bus.req_last  = rl;
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*DW +: DW]   = {48'h0, dat, 4'h0, 4'(i)};
            bus.req_dvalid[i*VW +: VW] = VW'(i);
        end
    endtask

    task automatic do_reset();
        rst_wr_n = 1'b0;
        drive(4'b0, 4'b0, 8'h00);
        step();
        rst_wr_n = 1'b1;
    endtask

    function automatic logic [31:0] stat(input logic [1:0] st, input logic [2:0] own,
                                         input logic ab, input logic [15:0] cnt);
        return {cnt, 10'h0, ab, own, st};
    endfunction

    function automatic vec_t mk(input logic rst, input logic tx, input logic [3:0] rv,
                                input logic [3:0] rl, input logic [7:0] dat, input logic e_v,
                                input logic [3:0] e_rdy, input logic [3:0] e_pid,
                                input logic [15:0] e_dat, input logic [1:0] e_dv,
                                input logic [1:0] e_st, input logic [2:0] e_own,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.tx = tx; v.rv = rv; v.rl = rl; v.dat = dat;
        v.e_v = e_v; v.e_rdy = e_rdy; v.e_pid = e_pid; v.e_dat = e_dat;
        v.e_dv = e_dv; v.e_st = e_st; v.e_own = e_own; v.e_cnt = e_cnt;
        return v;
    endfunction

    int   n_in, n_out;
    logic prev_stall, acc_in, acc_out, dr;
    logic [63:0] prev_dat, out_dat;

    initial begin
        // 3-flit message from req0, then reset and continuous single-flit traffic on all four.
        tbl[0]  = mk(0, 0, 4'b0000, 4'b0000, 8'h00, 0, 4'b0000, 4'h0, 16'h0000, 2'd0, 2'd0, 3'd0, 16'd0);
        tbl[1]  = mk(1, 1, 4'b0001, 4'b0000, 8'hD0, 0, 4'b0000, 4'h0, 16'h0000, 2'd0, 2'd0, 3'd0, 16'd0);
        tbl[2]  = mk(1, 1, 4'b0001, 4'b0000, 8'hD0, 0, 4'b0001, 4'h0, 16'h0000, 2'd0, 2'd1, 3'd0, 16'd0);
        tbl[3]  = mk(1, 1, 4'b0001, 4'b0000, 8'hD1, 1, 4'b0001, 4'hA, 16'hD000, 2'd0, 2'd1, 3'd0, 16'd0);
        tbl[4]  = mk(1, 1, 4'b0001, 4'b0001, 8'hD2, 1, 4'b0001, 4'hA, 16'hD100, 2'd0, 2'd1, 3'd0, 16'd0);
        tbl[5]  = mk(1, 1, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 4'hA, 16'hD200, 2'd0, 2'd0, 3'd0, 16'd1);
        tbl[6]  = mk(0, 1, 4'b0000, 4'b0000, 8'h00, 0, 4'b0000, 4'h0, 16'h0000, 2'd0, 2'd0, 3'd0, 16'd1);
        tbl[7]  = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 0, 4'b0000, 4'h0, 16'h0000, 2'd0, 2'd0, 3'd0, 16'd0);
        tbl[8]  = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 0, 4'b0001, 4'h0, 16'h0000, 2'd0, 2'd1, 3'd0, 16'd0);
        tbl[9]  = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 1, 4'b0000, 4'hA, 16'h1100, 2'd0, 2'd0, 3'd0, 16'd1);
        tbl[10] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 0, 4'b0010, 4'h0, 16'h0000, 2'd0, 2'd1, 3'd1, 16'd1);
        tbl[11] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 1, 4'b0000, 4'hB, 16'h1101, 2'd1, 2'd0, 3'd1, 16'd2);
        tbl[12] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 0, 4'b0100, 4'h0, 16'h0000, 2'd0, 2'd1, 3'd2, 16'd2);
        tbl[13] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 1, 4'b0000, 4'hC, 16'h1102, 2'd2, 2'd0, 3'd2, 16'd3);
        tbl[14] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 0, 4'b1000, 4'h0, 16'h0000, 2'd0, 2'd1, 3'd3, 16'd3);
        tbl[15] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 1, 4'b0000, 4'hD, 16'h1103, 2'd3, 2'd0, 3'd3, 16'd4);
        tbl[16] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 0, 4'b0001, 4'h0, 16'h0000, 2'd0, 2'd1, 3'd0, 16'd4);
        tbl[17] = mk(1, 1, 4'b1111, 4'b1111, 8'h11, 1, 4'b0000, 4'hA, 16'h1100, 2'd0, 2'd0, 3'd0, 16'd5);

        cfg_protid      = 16'hDCBA;
        rst_wr_n        = 1'b0;
        tx_online       = 1'b0;
        bus.dstrm_ready = 1'b1;
        drive(4'b0, 4'b0, 8'h00);
        step();
        step();

        for (int k = 0; k < NV; k++) begin
            rst_wr_n  = tbl[k].rst;
            tx_online = tbl[k].tx;
            drive(tbl[k].rv, tbl[k].rl, tbl[k].dat);
            #1;
            chk($sformatf("v%0d valid", k), 64'(bus.dstrm_valid), 64'(tbl[k].e_v));
            chk($sformatf("v%0d ready", k), 64'(bus.req_ready), 64'(tbl[k].e_rdy));
            chk($sformatf("v%0d status", k), 64'(arb_debug_status),
                64'(stat(tbl[k].e_st, tbl[k].e_own, 1'b0, tbl[k].e_cnt)));
            if (tbl[k].e_v) begin
                chk($sformatf("v%0d protid", k), 64'(bus.dstrm_protid), 64'(tbl[k].e_pid));
                chk($sformatf("v%0d data", k), bus.dstrm_data, 64'(tbl[k].e_dat));
                chk($sformatf("v%0d dvalid", k), 64'(bus.dstrm_dvalid), 64'(tbl[k].e_dv));
            end
            step();
        end

        // Lock hold: req1 owns the channel, drops valid mid-message, others wait.
        do_reset();
        tx_online = 1'b1;
        drive(4'b0010, 4'b0000, 8'h21); #1; step();
        drive(4'b1110, 4'b0000, 8'h22); #1;
        chk("h1 rdy owner1", 64'(bus.req_ready), 64'(4'b0010));
        step();
        drive(4'b1100, 4'b0000, 8'h23); #1;
        chk("h1 rdy gap", 64'(bus.req_ready), 64'(4'b0010));
        chk("h1 status gap", 64'(arb_debug_status), 64'(stat(ARB_LOCK, 3'd1, 1'b0, 16'd0)));
        step();
        for (int j = 0; j < 3; j++) begin
            drive(4'b1100, 4'b0000, 8'h23); #1;
            chk("h1 still locked", 64'(arb_debug_status), 64'(stat(ARB_LOCK, 3'd1, 1'b0, 16'd0)));
            chk("h1 no flit", 64'(bus.dstrm_valid), 64'(1'b0));
            step();
        end
        drive(4'b1110, 4'b0010, 8'h24); #1;
        chk("h1 rdy last", 64'(bus.req_ready), 64'(4'b0010));
        step();
        drive(4'b1100, 4'b0000, 8'h25); #1;
        chk("h1 last valid", 64'(bus.dstrm_valid), 64'(1'b1));
        chk("h1 last protid", 64'(bus.dstrm_protid), 64'(4'hB));
        chk("h1 last data", bus.dstrm_data, 64'h2401);
        chk("h1 released", 64'(arb_debug_status), 64'(stat(ARB_IDLE, 3'd1, 1'b0, 16'd1)));
        step();
        drive(4'b1100, 4'b0000, 8'h26); #1;
        chk("h1 next owner2", 64'(arb_debug_status), 64'(stat(ARB_LOCK, 3'd2, 1'b0, 16'd1)));
        chk("h1 rdy owner2", 64'(bus.req_ready), 64'(4'b0100));
        step();

        // Backpressure: 4-flit burst from req0 with dstrm_ready low for 5 cycles.
        do_reset();
        tx_online  = 1'b1;
        n_in       = 0;
        n_out      = 0;
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            dr = !(cyc >= 4 && cyc < 9);
            bus.dstrm_ready = dr;
            drive((n_in < 4) ? 4'b0001 : 4'b0000, (n_in == 3) ? 4'b0001 : 4'b0000, 8'(8'h40 + n_in));
            #1;
            if (prev_stall) begin
                chk("h2 hold valid", 64'(bus.dstrm_valid), 64'(1'b1));
                chk("h2 hold data", bus.dstrm_data, prev_dat);
            end
            if (bus.dstrm_valid && !dr) begin
                chk("h2 stall rdy", 64'(bus.req_ready), 64'(4'b0000));
            end
            prev_stall = bus.dstrm_valid && !dr;
            prev_dat   = bus.dstrm_data;
            acc_in     = bus.req_valid[0] & bus.req_ready[0];
            acc_out    = bus.dstrm_valid & dr;
            out_dat    = bus.dstrm_data;
            step();
            if (acc_in) n_in++;
            if (acc_out) begin
                chk("h2 flit order", out_dat, 64'h4000 + (64'(n_out) << 8));
                n_out++;
            end
        end
        chk("h2 flit count", 64'(n_out), 64'd4);
        bus.dstrm_ready = 1'b1;

        // Link drop after 2 of 4 flits, then mid-message reset.
        do_reset();
        tx_online = 1'b1;
        drive(4'b0001, 4'b0000, 8'h50); #1; step();
        drive(4'b0001, 4'b0000, 8'h50); #1;
        chk("h3 rdy0", 64'(bus.req_ready), 64'(4'b0001));
        step();
        drive(4'b0001, 4'b0000, 8'h51); #1; step();
        tx_online = 1'b0;
        bus.dstrm_ready = 1'b0;
        drive(4'b0011, 4'b0000, 8'h52); #1;
        chk("h3 rdy txoff", 64'(bus.req_ready), 64'(4'b0000));
        step();
        tx_online = 1'b1;
        #1;
        chk("h3 drain status", 64'(arb_debug_status), 64'(stat(ARB_DRAIN, 3'd0, 1'b1, 16'd0)));
        chk("h3 drain valid", 64'(bus.dstrm_valid), 64'(1'b1));
        chk("h3 drain data", bus.dstrm_data, 64'h5100);
        chk("h3 drain rdy", 64'(bus.req_ready), 64'(4'b0000));
        step();
        bus.dstrm_ready = 1'b1;
        #1;
        chk("h3 drain rdy free", 64'(bus.req_ready), 64'(4'b0000));
        step();
        #1;
        chk("h3 drained valid", 64'(bus.dstrm_valid), 64'(1'b0));
        chk("h3 still drain", 64'(arb_debug_status), 64'(stat(ARB_DRAIN, 3'd0, 1'b1, 16'd0)));
        step();
        #1;
        chk("h3 idle sticky", 64'(arb_debug_status), 64'(stat(ARB_IDLE, 3'd0, 1'b1, 16'd0)));
        step();
        drive(4'b0011, 4'b0000, 8'h53); #1;
        chk("h3 next owner1", 64'(arb_debug_status), 64'(stat(ARB_LOCK, 3'd1, 1'b1, 16'd0)));
        chk("h3 rdy owner1", 64'(bus.req_ready), 64'(4'b0010));
        step();
        rst_wr_n = 1'b0;
        #1;
        chk("h4 pending flit", 64'(bus.dstrm_valid), 64'(1'b1));
        step();
        rst_wr_n = 1'b1;
        drive(4'b0011, 4'b0000, 8'h54); #1;
        chk("h4 valid", 64'(bus.dstrm_valid), 64'(1'b0));
        chk("h4 rdy", 64'(bus.req_ready), 64'(4'b0000));
        chk("h4 protid", 64'(bus.dstrm_protid), 64'(4'h0));
        chk("h4 data", bus.dstrm_data, 64'h0);
        chk("h4 dvalid", 64'(bus.dstrm_dvalid), 64'(2'b00));
        chk("h4 status", 64'(arb_debug_status), 64'(32'h0));
        step();
        #1;
        chk("h4 rr reset", 64'(arb_debug_status), 64'(stat(ARB_LOCK, 3'd0, 1'b0, 16'd0)));
        chk("h4 rdy owner0", 64'(bus.req_ready), 64'(4'b0001));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
